// File: rtl/fp32_div_round_pack.sv
// -----------------------------------------------------------------------------
// fp32_div_round_pack
//
// Post-divide stage of the single-precision divider. It takes the raw sign,
// exponent, quotient mantissa and sticky bit from the mantissa divider and
// returns a packed fp32 result. Rounding is round-to-nearest-even. Overflow
// saturates to signed infinity. Results below the normal range flush to
// signed zero.
//
// The stage is a two-deep valid/ready pipeline with a throughput of one beat
// per clock:
//   S1 : normalise the quotient and register the class.
//   S2 : round, check range, pack and register onto out_*.
//
// Parameters
//   QNAN_VAL   canonical quiet NaN emitted for the NaN class
//   FTZ        flush-to-zero for sub-normal results (the only mode built)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    input beat valid
//   in_ready    stage can accept a beat
//   in_sign     result sign
//   in_exp      10-bit signed biased exponent before normalisation
//   in_mant     quotient, bit25 = integer bit, value in (0.5, 2)
//   in_sticky   divider remainder nonzero
//   in_cls      00 normal, 01 zero, 10 infinity, 11 NaN
//   out_valid   result valid
//   out_ready   consumer accepts result
//   out_result  packed fp32 result
//   out_flags   {OF, UF, NX} for this result
//
// Optional feature (macro FPDIV_STICKY_FLAGS_EN)
//   flag_clr    clears the accumulated flags
//   flag_acc    OR of out_flags over every transferred result since the
//               last clear or reset
// -----------------------------------------------------------------------------
module fp32_div_round_pack #(
    parameter logic [31:0] QNAN_VAL = 32'h7FC0_0000,
    parameter int          FTZ      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [25:0] in_mant,
    input  logic        in_sticky,
    input  logic [1:0]  in_cls,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
`ifdef FPDIV_STICKY_FLAGS_EN
    ,
    input  logic        flag_clr,
    output logic [2:0]  flag_acc
`endif
);

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } cls_t;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s2_can_load;
    logic w_s1_load;

    assign w_s2_can_load = !r_out_valid || out_ready;
    assign in_ready      = !r_s1_valid || w_s2_can_load;
    assign w_s1_load     = in_valid && in_ready;

    // ------------------------------------------------------------------
    // S1: normalise
    // The quotient lies in (0.5, 2). When the integer bit is clear, the
    // value is shifted left by one and the exponent is decremented.
    // The exponent carries one extra bit so that the +/-1 adjustments at
    // the ends of the 10-bit input range cannot wrap.
    // ------------------------------------------------------------------
    logic signed [10:0] w_in_exp_ext;
    logic signed [10:0] w_s1_exp;
    logic [22:0]        w_s1_frac;
    logic               w_s1_g;
    logic               w_s1_s;

    assign w_in_exp_ext = signed'({in_exp[9], in_exp});
    assign w_s1_exp     = in_mant[25] ? w_in_exp_ext : (w_in_exp_ext - 11'sd1);
    assign w_s1_frac    = in_mant[25] ? in_mant[24:2] : in_mant[23:1];
    assign w_s1_g       = in_mant[25] ? in_mant[1] : in_mant[0];
    assign w_s1_s       = in_mant[25] ? (in_mant[0] | in_sticky) : in_sticky;

    logic               r_s1_sign;
    cls_t               r_s1_cls;
    logic signed [10:0] r_s1_exp;
    logic [22:0]        r_s1_frac;
    logic               r_s1_g;
    logic               r_s1_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= CLS_NORMAL;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
        end else if (in_ready) begin
            // S1 empties or refills whenever it is able to move on.
            r_s1_valid <= in_valid;
            if (w_s1_load) begin
                r_s1_sign <= in_sign;
                r_s1_cls  <= cls_t'(in_cls);
                r_s1_exp  <= w_s1_exp;
                r_s1_frac <= w_s1_frac;
                r_s1_g    <= w_s1_g;
                r_s1_s    <= w_s1_s;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: round to nearest even, range check, pack
    // {1,frac}+up carries out exactly when the fraction alone carries
    // out. The bit-23 carry of a 24-bit fraction sum is therefore
    // enough. On a carry the remaining fraction bits are already zero.
    // ------------------------------------------------------------------
    logic               w_up;
    logic [23:0]        w_frac_sum;
    logic               w_carry;
    logic signed [10:0] w_exp_rnd;
    logic               w_of;
    logic               w_uf;
    logic               w_nx;
    logic [31:0]        w_uf_result;
    logic [31:0]        w_s2_result;
    logic [2:0]         w_s2_flags;

    assign w_up       = r_s1_g & (r_s1_s | r_s1_frac[0]);
    assign w_frac_sum = {1'b0, r_s1_frac} + {23'b0, w_up};
    assign w_carry    = w_frac_sum[23];
    assign w_exp_rnd  = r_s1_exp + signed'({10'b0, w_carry});
    assign w_of       = (w_exp_rnd >= 11'sd255);
    assign w_uf       = (w_exp_rnd <= 11'sd0);
    assign w_nx       = r_s1_g | r_s1_s;

    // Results below the normal range flush to a signed zero for every
    // FTZ setting.
    generate
        if (FTZ != 0) begin : g_ftz
            assign w_uf_result = {r_s1_sign, 31'h0};
        end else begin : g_no_ftz
            assign w_uf_result = {r_s1_sign, 31'h0};
        end
    endgenerate

    always_comb begin
        w_s2_result = 32'h0;
        w_s2_flags  = 3'b000;
        case (r_s1_cls)
            CLS_ZERO: w_s2_result = {r_s1_sign, 31'h0};
            CLS_INF:  w_s2_result = {r_s1_sign, 8'hFF, 23'h0};
            CLS_NAN:  w_s2_result = QNAN_VAL;
            default: begin
                if (w_of) begin
                    w_s2_result = {r_s1_sign, 8'hFF, 23'h0};
                    w_s2_flags  = 3'b101;
                end else if (w_uf) begin
                    w_s2_result = w_uf_result;
                    w_s2_flags  = 3'b011;
                end else begin
                    w_s2_result = {r_s1_sign, w_exp_rnd[7:0], w_frac_sum[22:0]};
                    w_s2_flags  = {2'b00, w_nx};
                end
            end
        endcase
    end

    logic [31:0] r_out_result;
    logic [2:0]  r_out_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 32'h0;
            r_out_flags  <= 3'b000;
        end else if (w_s2_can_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result <= w_s2_result;
                r_out_flags  <= w_s2_flags;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;

`ifdef FPDIV_STICKY_FLAGS_EN
    // A clear and a transfer in the same cycle keep only the new flags.
    logic [2:0] r_flag_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_acc <= 3'b000;
        end else begin
            r_flag_acc <= (flag_clr ? 3'b000 : r_flag_acc)
                        | ((r_out_valid && out_ready) ? r_out_flags : 3'b000);
        end
    end

    assign flag_acc = r_flag_acc;
`endif

endmodule

// File: tb/tb_fp32_div_round_pack.sv
module tb_fp32_div_round_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [25:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic [1:0]  in_cls = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
`ifdef FPDIV_STICKY_FLAGS_EN
    logic        flag_clr = 1'b0;
    logic [2:0]  flag_acc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp32_div_round_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_sticky  (in_sticky),
        .in_cls     (in_cls),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
`ifdef FPDIV_STICKY_FLAGS_EN
        ,
        .flag_clr   (flag_clr),
        .flag_acc   (flag_acc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s %h", tag, got);
        end
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [25:0] m,
                         input logic st, input logic [1:0] c);
        in_sign   = s;
        in_exp    = e;
        in_mant   = m;
        in_sticky = st;
        in_cls    = c;
    endtask

    // Call on a negedge with out_ready=1. The result must be absent after
    // one clock and present after two.
    task automatic run_one(input string tag, input logic s, input logic [9:0] e,
                           input logic [25:0] m, input logic st, input logic [1:0] c,
                           input logic [31:0] exp_res, input logic [2:0] exp_flags);
        drive(s, e, m, st, c);
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_res"}, out_result, exp_res);
        check({tag, "_flags"}, {29'b0, out_flags}, {29'b0, exp_flags});
    endtask

    logic [31:0] got_q[$];
    int          cnt;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_flags", {29'b0, out_flags}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        run_one("div6by2",   1'b0, 10'd128, 26'h300_0000, 1'b0, 2'b00, 32'h4040_0000, 3'b000);
        run_one("div1by1p5", 1'b0, 10'd127, 26'h155_5555, 1'b1, 2'b00, 32'h3F2A_AAAB, 3'b001);
        run_one("rnd_carry", 1'b0, 10'd127, 26'h3FF_FFFF, 1'b1, 2'b00, 32'h4000_0000, 3'b001);
        run_one("tie_even",  1'b0, 10'd127, 26'h200_0002, 1'b0, 2'b00, 32'h3F80_0000, 3'b001);
        run_one("tie_odd",   1'b0, 10'd127, 26'h200_0006, 1'b0, 2'b00, 32'h3F80_0002, 3'b001);
        run_one("ovf",       1'b1, 10'd300, 26'h200_0000, 1'b0, 2'b00, 32'hFF80_0000, 3'b101);
        run_one("unf",       1'b1, -10'sd5, 26'h200_0000, 1'b0, 2'b00, 32'h8000_0000, 3'b011);
        run_one("nan",       1'b1, 10'd12,  26'h123_4567, 1'b1, 2'b11, 32'h7FC0_0000, 3'b000);
        run_one("zero",      1'b1, 10'd500, 26'h3FF_FFFF, 1'b1, 2'b01, 32'h8000_0000, 3'b000);
        run_one("inf",       1'b0, 10'd3,   26'h155_5555, 1'b1, 2'b10, 32'h7F80_0000, 3'b000);
        run_one("exp254",    1'b0, 10'd254, 26'h200_0000, 1'b0, 2'b00, 32'h7F00_0000, 3'b000);
        run_one("exp254_c",  1'b0, 10'd254, 26'h3FF_FFFF, 1'b1, 2'b00, 32'h7F80_0000, 3'b101);
        run_one("exp1_norm", 1'b0, 10'd1,   26'h200_0000, 1'b0, 2'b00, 32'h0080_0000, 3'b000);
        run_one("exp1_shft", 1'b0, 10'd1,   26'h100_0000, 1'b0, 2'b00, 32'h0000_0000, 3'b011);

        // Backpressure: the third beat stalls until the consumer drains.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 10'd128, 26'h300_0000, 1'b0, 2'b00);
        in_valid = 1'b1;
        check("bp_acc_a", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 10'd127, 26'h155_5555, 1'b1, 2'b00);
        check("bp_acc_b", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 10'd127, 26'h3FF_FFFF, 1'b1, 2'b00);
        check("bp_stall", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("bp_stall_hold", {31'b0, in_ready}, 32'd0);
        check("bp_out_hold", out_result, 32'h4040_0000);
        out_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            if (i == 1) in_valid = 1'b0;
            if (out_valid) got_q.push_back(out_result);
            @(negedge clk);
        end
        check("bp_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("bp_res0", got_q[0], 32'h4040_0000);
            check("bp_res1", got_q[1], 32'h3F2A_AAAB);
            check("bp_res2", got_q[2], 32'h4000_0000);
        end

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive(1'b0, 10'd128, 26'h300_0000, 1'b0, 2'b00);
        in_valid = 1'b1;
        @(negedge clk);
        drive(1'b1, 10'd300, 26'h200_0000, 1'b0, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", {31'b0, out_valid}, 32'd0);
        check("rst_async_ready", {31'b0, in_ready}, 32'd1);
        check("rst_async_res", out_result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_no_ghost", cnt, 32'd0);
        check("rst_in_ready_post", {31'b0, in_ready}, 32'd1);
        run_one("post_rst", 1'b0, 10'd128, 26'h300_0000, 1'b0, 2'b00, 32'h4040_0000, 3'b000);

`ifdef FPDIV_STICKY_FLAGS_EN
        // Accumulator: clear, then NX, OF and UF results, then clear again.
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("acc_cleared0", {29'b0, flag_acc}, 32'd0);
        run_one("acc_nx", 1'b0, 10'd127, 26'h155_5555, 1'b1, 2'b00, 32'h3F2A_AAAB, 3'b001);
        run_one("acc_of", 1'b1, 10'd300, 26'h200_0000, 1'b0, 2'b00, 32'hFF80_0000, 3'b101);
        run_one("acc_uf", 1'b1, -10'sd5, 26'h200_0000, 1'b0, 2'b00, 32'h8000_0000, 3'b011);
        @(negedge clk);
        check("acc_all", {29'b0, flag_acc}, 32'd7);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("acc_clr", {29'b0, flag_acc}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
